sum_processor: RTL

Parametrised dedicated microprocessor that computes the triangular sum 1 + 2 + … + n of an unsigned input n using a controller FSM and a small register/adder/mux datapath. It is the sequential successor to the team's 8-bit 2-to-1 mux and OR-gate primitives: the data width is generalised, and the previously empty control unit becomes a real state machine. It sits between a host that issues start/n and a consumer that reads sum on done.

---
 rtl/sum_processor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sum_processor.sv
// -----------------------------------------------------------------------------
// sum_processor
//
// Small dedicated processor that computes the triangular sum 1 + 2 + ... + n
// of an unsigned operand. A four-state controller (IDLE/TEST/ADD/DONE) drives
// a datapath made of an n register, a sum register, a sticky overflow flag, a
// WIDTH+1-bit adder and a WIDTH-bit 2-to-1 mux that selects the next sum
// value (zero on load, adder output on ADD).
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - computation request, only looked at in IDLE
//   n_in   - unsigned operand, captured on the edge that accepts start
//   sum    - result register, modulo 2^WIDTH
//   ovf    - sticky overflow, set if any addition carried out of WIDTH bits
//   busy   - high whenever the controller is not in IDLE
//   done   - one-cycle pulse while the controller is in DONE
//
// Latency: for operand n the controller spends 2n + 2 cycles outside IDLE
// (n TEST/ADD pairs, a final TEST and one DONE cycle).
// -----------------------------------------------------------------------------
module sum_processor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] n_reg;
    logic             load;
    logic             add_en;
    logic             n_zero;
    logic [WIDTH:0]   add_result;
    logic [WIDTH-1:0] sum_next;

    // ------------------------------------------------------------------
    // Datapath combinational logic
    // ------------------------------------------------------------------
    assign n_zero     = ~(|n_reg);
    assign add_result = {1'b0, sum} + {1'b0, n_reg};

    // Per-bit 2-to-1 mux feeding the sum register: zero on load, adder
    // output otherwise. The register only updates when load or add_en is
    // asserted, so the mux output is irrelevant in other states.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum_mux
            assign sum_next[gi] = load ? 1'b0 : add_result[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and control outputs. busy/done depend only on
    // the registered state, never on start.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        add_en     = 1'b0;
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = TEST;
                end
            end
            TEST: begin
                state_next = n_zero ? DONE : ADD;
            end
            ADD: begin
                add_en     = 1'b1;
                state_next = TEST;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. ADD is only reachable with n_reg != 0, so the
    // decrement can never wrap below zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg <= '0;
            sum   <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            n_reg <= n_in;
            sum   <= sum_next;
            ovf   <= 1'b0;
        end else if (add_en) begin
            n_reg <= n_reg - ONE;
            sum   <= sum_next;
            ovf   <= ovf | add_result[WIDTH];
        end
    end

endmodule
